// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter request conditioner.
//   - master indices M1/M2/M3 (bit positions in the want/req/done vectors)
//   - arbiter grant codes carried on accmodule
//   - channel FSM state encoding
package arb_pkg;

  localparam int unsigned M1 = 0;
  localparam int unsigned M2 = 1;
  localparam int unsigned M3 = 2;

  typedef logic [1:0] acc_t;

  localparam acc_t ACC_NONE = 2'b00;
  localparam acc_t state_M1 = 2'b01;
  localparam acc_t state_M2 = 2'b10;
  localparam acc_t state_M3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } chan_state_e;

  // Master index -> grant code (M1 -> 01, M2 -> 10, M3 -> 11).
  function automatic acc_t grant_code(input int unsigned idx);
    return acc_t'(idx + 1);
  endfunction

endpackage

// File: rtl/arb_req_conditioner_if.sv
// Handshake bundle between the masters' intent signals, the arbiter grant
// and the conditioned req/done pulses.
//   master modport: drives want/finish/accmodule, observes conditioner outputs
//   slave  modport: the conditioner itself
// preempt_cnt packs three CNT_W-bit counters, M1 in the LSB field.
interface arb_req_conditioner_if
  import arb_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);
  logic [2:0]         want;
  logic [2:0]         finish;
  acc_t               accmodule;
  logic [2:0]         req;
  logic [2:0]         done;
  logic [2:0]         pending;
  logic [2:0]         owning;
  logic [3*CNT_W-1:0] preempt_cnt;
  logic [2:0]         timeout_err;

  modport master (
    output want, finish, accmodule,
    input  req, done, pending, owning, preempt_cnt, timeout_err
  );

  modport slave (
    input  want, finish, accmodule,
    output req, done, pending, owning, preempt_cnt, timeout_err
  );
endinterface

// File: rtl/arb_req_chan.sv
// Single-master request channel: turns a level want/finish intent into
// one-cycle req/done pulses for the arbiter and tracks grant ownership.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   want_i          master needs the resource (level)
//   finish_i        work complete, only looked at while owning
//   acc_i           arbiter grant code
//   req_o, done_o   request / release pulses
//   pending_o       channel in WAIT
//   owning_o        channel in OWN
//   preempt_cnt_o   saturating count of grants lost before finish
//   timeout_err_o   sticky WAIT timeout flag (ARB_REQ_TIMEOUT_EN only, else 0)
// Optional feature macro: ARB_REQ_TIMEOUT_EN
module arb_req_chan
  import arb_pkg::*;
#(
  parameter acc_t        CODE      = state_M1,
  parameter int unsigned REREQ_GAP = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             want_i,
  input  logic             finish_i,
  input  acc_t             acc_i,
  output logic             req_o,
  output logic             done_o,
  output logic             pending_o,
  output logic             owning_o,
  output logic [CNT_W-1:0] preempt_cnt_o,
  output logic             timeout_err_o
);

  localparam int unsigned WMAX = (REREQ_GAP > TIMEOUT) ? REREQ_GAP : TIMEOUT;
  localparam int unsigned WCW  = $clog2(WMAX + 1);

  localparam logic [WCW-1:0]   GAP    = WCW'(REREQ_GAP);
  localparam logic [WCW-1:0]   GAP_M1 = WCW'(REREQ_GAP - 1);
  localparam logic [WCW-1:0]   WSAT   = WCW'(WMAX);
  localparam logic [CNT_W-1:0] PSAT   = '1;

  chan_state_e      state_q;
  logic [WCW-1:0]   wcnt_q;
  logic [WCW-1:0]   wcnt_inc;
  logic             req_q;
  logic             done_q;
  logic             pend_q;
  logic             own_q;
  logic [CNT_W-1:0] pcnt_q;

  assign wcnt_inc = (wcnt_q == WSAT) ? wcnt_q : wcnt_q + WCW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      own_q   <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (want_i) begin
            req_q   <= 1'b1;
            pend_q  <= 1'b1;
            wcnt_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Grant beats a want drop: release then happens through OWN.
          if (acc_i == CODE) begin
            pend_q  <= 1'b0;
            own_q   <= 1'b1;
            wcnt_q  <= '0;
            state_q <= OWN;
          end else if (!want_i) begin
            pend_q  <= 1'b0;
            wcnt_q  <= '0;
            state_q <= IDLE;
          end else if (wcnt_inc >= GAP) begin
            req_q  <= 1'b1;
            wcnt_q <= '0;
          end else begin
            wcnt_q <= wcnt_inc;
          end
        end
        OWN: begin
          // Completion beats grant loss: no preemption is counted.
          if (finish_i || !want_i) begin
            done_q  <= 1'b1;
            own_q   <= 1'b0;
            state_q <= REL;
          end else if (acc_i != CODE) begin
            if (pcnt_q != PSAT) pcnt_q <= pcnt_q + CNT_W'(1);
            own_q   <= 1'b0;
            pend_q  <= 1'b1;
            // Preset so the re-request fires on the cycle after WAIT entry.
            wcnt_q  <= GAP_M1;
            state_q <= WAIT;
          end
        end
        REL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_o         = req_q;
  assign done_o        = done_q;
  assign pending_o     = pend_q;
  assign owning_o      = own_q;
  assign preempt_cnt_o = pcnt_q;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam logic [WCW-1:0] TO    = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] TO_M1 = WCW'(TIMEOUT - 1);

  logic [WCW-1:0] tcnt_q;
  logic           terr_q;

  // Counts consecutive WAIT cycles; re-request pulses do not reset it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else if (state_q == WAIT) begin
      if (tcnt_q != TO) tcnt_q <= tcnt_q + WCW'(1);
      if (tcnt_q == TO_M1) terr_q <= 1'b1;
    end else begin
      tcnt_q <= '0;
    end
  end

  assign timeout_err_o = terr_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule

// File: rtl/arb_req_conditioner.sv
// Request conditioner in front of the 3-master arbiter. Three independent
// arb_req_chan instances, one per master; this level only packs outputs.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         arb_req_conditioner_if.slave: want, finish, accmodule in;
//               req, done, pending, owning, preempt_cnt, timeout_err out
// Optional feature macro: ARB_REQ_TIMEOUT_EN (per-channel WAIT timeout flag)
module arb_req_conditioner
  import arb_pkg::*;
#(
  parameter int unsigned REREQ_GAP = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  arb_req_conditioner_if.slave  bus
);

  logic             req_w  [3];
  logic             done_w [3];
  logic             pend_w [3];
  logic             own_w  [3];
  logic             terr_w [3];
  logic [CNT_W-1:0] pcnt_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_chan
    arb_req_chan #(
      .CODE      (grant_code(g)),
      .REREQ_GAP (REREQ_GAP),
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .want_i        (bus.want[g]),
      .finish_i      (bus.finish[g]),
      .acc_i         (bus.accmodule),
      .req_o         (req_w[g]),
      .done_o        (done_w[g]),
      .pending_o     (pend_w[g]),
      .owning_o      (own_w[g]),
      .preempt_cnt_o (pcnt_w[g]),
      .timeout_err_o (terr_w[g])
    );
  end

  assign bus.req         = {req_w[2],  req_w[1],  req_w[0]};
  assign bus.done        = {done_w[2], done_w[1], done_w[0]};
  assign bus.pending     = {pend_w[2], pend_w[1], pend_w[0]};
  assign bus.owning      = {own_w[2],  own_w[1],  own_w[0]};
  assign bus.timeout_err = {terr_w[2], terr_w[1], terr_w[0]};
  assign bus.preempt_cnt = {pcnt_w[2], pcnt_w[1], pcnt_w[0]};

endmodule

// File: doc/arb_req_conditioner.md
Name: arb_req_conditioner

Overview:
- Sits directly upstream of the 3-master arbiter (M1 high-priority interrupter; M2/M3 round-robin with two-cycle slots).
- Converts each master's level-sensitive "want/finish" intent into the arbiter's pulse protocol on req[2:0] and done[2:0].
- Watches accmodule to track grant ownership and re-requests after preemption or a slot expiry.
- Guarantees by construction the arbiter input rules: req and done are one-cycle pulses, and req[i] and done[i] are never high together.

Parameters:
- REREQ_GAP, 4: cycles in WAIT without a grant before req[i] is re-pulsed (minimum 2).
- CNT_W, 8: width of each per-master saturating preemption counter.
- TIMEOUT, 64: WAIT cycles before the timeout error is flagged (used only with ARB_REQ_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- want  in  3  level per master (bit0=M1, bit1=M2, bit2=M3); high while the master needs the resource
- finish  in  3  per master; sampled only in OWN; high means the work is complete
- accmodule  in  2  arbiter grant: 00 none, 01 M1, 10 M2, 11 M3
- req  out  3  request pulses to the arbiter
- done  out  3  release pulses to the arbiter
- pending  out  3  master i is in WAIT
- owning  out  3  master i is in OWN
- preempt_cnt  out  3*CNT_W  per-master count of grants lost before finish; M1 occupies the LSB field
- timeout_err  out  3  sticky per-master timeout flag

Behaviour:
- One independent channel FSM per master i. States: IDLE, WAIT, OWN, REL.
- Outputs are registered. Reset, including mid-operation, gives on the next edge:
  - all states IDLE
  - req, done, pending, owning, timeout_err = 0
  - preempt_cnt = 0
  - wait counter = 0
- IDLE:
  - want[i]=1 -> req[i]=1 on the next cycle; go to WAIT; clear the wait counter.
- WAIT:
  - The wait counter increments each cycle.
  - accmodule==code(i) -> go to OWN; clear the counter.
  - want[i]=0 -> go to IDLE; no done pulse.
  - Counter reaches REREQ_GAP with no grant -> pulse req[i] once; clear the counter.
  - req[i] is therefore never high on consecutive cycles.
  - Grant takes priority over want drop in the same cycle: enter OWN, then release via OWN.
- OWN:
  - finish[i]=1 or want[i]=0 -> done[i]=1 for one cycle; go to REL.
  - Otherwise, accmodule!=code(i) (grant lost to preemption or slot expiry) -> preempt_cnt[i] increments, saturating at 2^CNT_W-1; go to WAIT with the counter preset to REREQ_GAP-1, so req[i] is re-pulsed one cycle later.
  - finish wins over loss of grant in the same cycle: done is pulsed and preempt_cnt is unchanged.
- REL:
  - One cooldown cycle; done[i] falls; req[i] is held 0 regardless of want; go to IDLE.
  - want still high re-requests from IDLE, so the earliest new req[i] is 2 cycles after done[i].
- Invariants:
  - req[i] and done[i] are mutually exclusive.
  - done[i] is never asserted on consecutive cycles.
  - done is only issued from OWN.
- Channels do not interact; any mix of simultaneous wants is passed straight to the arbiter for tie-breaking.
- Counter widths: the wait counter is $clog2(max(REREQ_GAP,TIMEOUT)+1) bits and saturates.

Optional Feature:
- Macro ARB_REQ_TIMEOUT_EN.
- When defined: a separate per-channel counter counts consecutive cycles in WAIT.
  - At TIMEOUT it sets timeout_err[i], which stays set until reset.
  - The counter clears on entering OWN or IDLE.
  - Re-request pulses continue unchanged.
- When not defined: timeout_err is tied to 0 and no timeout counter logic exists.

Decomposition:
- Shared package arb_pkg holds:
  - master indices M1=0, M2=1, M3=2
  - grant codes state_M1=2'b01, state_M2=2'b10, state_M3=2'b11, and none=2'b00
  - typedef acc_t (logic [1:0])
  - enum chan_state_e {IDLE, WAIT, OWN, REL}
- One sub-module, arb_req_chan: a single-master FSM parameterised by its grant code. It is instantiated three times in a generate loop; the top only concatenates outputs.

Test Plan:
- Reset asserted with all channels in OWN -> next cycle req=000, done=000, owning=000, preempt_cnt=0.
- want=010 at cycle 0, accmodule=10 at cycle 2, finish[1]=1 at cycle 5 -> req=010 at cycle 1 only, owning[1]=1 from cycle 3, done=010 at cycle 6 only, req[1]=0 at cycle 7.
- want=100 held, accmodule stays 00 -> req[2] pulses at cycles 1, 5, 9 (REREQ_GAP=4), never two adjacent cycles.
- M3 in OWN, accmodule changes 11->01 (M1 interrupts) -> preempt_cnt[M3]=1, req[2] pulses 2 cycles later; done[2] not pulsed.
- In OWN, finish[1]=1 in the same cycle accmodule drops to 00 -> done[1] pulse, preempt_cnt[M2] unchanged, state REL then IDLE.
- With ARB_REQ_TIMEOUT_EN and TIMEOUT=8, want=001 and no grant -> timeout_err=001 after 8 WAIT cycles, still set after a later grant; without the macro, timeout_err=000 throughout.
